// File: rtl/datapath_pkg.sv
// Shared encodings for the multi-cycle datapath control: FSM states, opcode/funct fields, ALU codes.
// No logic here beyond the legal-opcode helper.
package datapath_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/datapath_controller_alu_decoder.sv
// R-type funct to ALU operation decode, purely combinational (zero latency, no handshake).
// Unknown funct codes fall back to ADD and raise funct_illegal.
module alu_decoder
    import datapath_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the single-register-file datapath; 2-5 cycles per instruction plus memory stalls.
// Stalls on memReady in FETCH/MEMORY, bounded by MEM_WAIT_MAX before flagging busErr.
module datapath_controller
    import datapath_pkg::*;
#(
    parameter int N            = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] instruction,
    input  logic         zero,
    input  logic         memReady,
    output logic         memToReg,
    output logic         pcSrc,
    output logic         aluSrc,
    output logic         regDst,
    output logic         writeEnable,
    output logic         jump,
    output logic [3:0]   aluControl,
    output logic         pcEnable,
    output logic         irEnable,
    output logic         memRead,
    output logic         memWrite,
    output logic         illegal,
    output logic         busErr,
    output logic [2:0]   state
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [2:0] FETCH     = ST_FETCH;
    localparam logic [2:0] DECODE    = ST_DECODE;
    localparam logic [2:0] EXECUTE   = ST_EXECUTE;
    localparam logic [2:0] MEMORY    = ST_MEMORY;
    localparam logic [2:0] WRITEBACK = ST_WRITEBACK;

    logic [2:0]    cur, nxt;
    logic [5:0]    op_q, fn_q;
    logic [CW-1:0] wait_q;
    logic          ill_q, berr_q;
    logic [5:0]    dec_op;
    logic          timeout;
    logic [3:0]    r_alu;
    logic          r_bad;
    logic          set_ill, set_berr;
    logic          m2r_c, pcs_c, alus_c, rdst_c, we_c, jmp_c, pce_c, ire_c, mrd_c, mwr_c;
    logic [3:0]    aluc_c;
    logic          unused_fields;

    assign dec_op        = instruction[N-1:N-6];
    assign unused_fields = ^instruction[N-7:6];
    assign timeout       = (wait_q == CW'(MEM_WAIT_MAX));

    alu_decoder u_alu_decoder (
        .funct         (fn_q),
        .alu_control   (r_alu),
        .funct_illegal (r_bad)
    );

    always_comb begin
        nxt      = cur;
        m2r_c    = 1'b0;
        pcs_c    = 1'b0;
        alus_c   = 1'b0;
        rdst_c   = 1'b0;
        we_c     = 1'b0;
        jmp_c    = 1'b0;
        pce_c    = 1'b0;
        ire_c    = 1'b0;
        mrd_c    = 1'b0;
        mwr_c    = 1'b0;
        aluc_c   = ALU_ADD;
        set_ill  = 1'b0;
        set_berr = 1'b0;
        case (cur)
            FETCH: begin
                // A fetch timeout just retries; the PC has not moved, so no pcEnable.
                if (timeout) begin
                    set_berr = 1'b1;
                end else begin
                    mrd_c = 1'b1;
                    if (memReady) begin
                        ire_c = 1'b1;
                        nxt   = DECODE;
                    end
                end
            end
            DECODE: begin
                if (dec_op == OP_J) begin
                    jmp_c = 1'b1;
                    pce_c = 1'b1;
                    nxt   = FETCH;
                end else if (!is_legal_op(dec_op)) begin
                    set_ill = 1'b1;
                    pce_c   = 1'b1;
                    nxt     = FETCH;
                end else begin
                    nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                case (op_q)
                    OP_RTYPE: begin
                        if (r_bad) begin
                            set_ill = 1'b1;
                            pce_c   = 1'b1;
                            nxt     = FETCH;
                        end else begin
                            aluc_c = r_alu;
                            nxt    = WRITEBACK;
                        end
                    end
                    OP_ADDI: begin
                        alus_c = 1'b1;
                        nxt    = WRITEBACK;
                    end
                    OP_LW, OP_SW: begin
                        alus_c = 1'b1;
                        nxt    = MEMORY;
                    end
                    OP_BEQ: begin
                        aluc_c = ALU_SUB;
                        pcs_c  = zero;
                        pce_c  = 1'b1;
                        nxt    = FETCH;
                    end
                    default: nxt = FETCH;
                endcase
            end
            MEMORY: begin
                alus_c = 1'b1;
                if (timeout) begin
                    set_berr = 1'b1;
                    pce_c    = 1'b1;
                    nxt      = FETCH;
                end else if (op_q == OP_LW) begin
                    mrd_c = 1'b1;
                    if (memReady) nxt = WRITEBACK;
                end else begin
                    mwr_c = 1'b1;
                    if (memReady) begin
                        pce_c = 1'b1;
                        nxt   = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                we_c  = 1'b1;
                pce_c = 1'b1;
                nxt   = FETCH;
                if (op_q == OP_RTYPE) rdst_c = 1'b1;
                if (op_q == OP_LW) begin
                    alus_c = 1'b1;
                    m2r_c  = 1'b1;
                end
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur    <= FETCH;
            op_q   <= '0;
            fn_q   <= '0;
            wait_q <= '0;
            ill_q  <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= dec_op;
                fn_q <= instruction[5:0];
            end
            if (set_ill)  ill_q  <= 1'b1;
            if (set_berr) berr_q <= 1'b1;
            if (nxt != cur || timeout)
                wait_q <= '0;
            else if ((cur == FETCH || cur == MEMORY) && !memReady)
                wait_q <= wait_q + CW'(1);
        end
    end

    // Gating with reset makes the bus requests drop immediately on an async reset, not at the next edge.
    assign memToReg    = reset & m2r_c;
    assign pcSrc       = reset & pcs_c;
    assign aluSrc      = reset & alus_c;
    assign regDst      = reset & rdst_c;
    assign writeEnable = reset & we_c;
    assign jump        = reset & jmp_c;
    assign pcEnable    = reset & pce_c;
    assign irEnable    = reset & ire_c;
    assign memRead     = reset & mrd_c;
    assign memWrite    = reset & mwr_c;
    assign aluControl  = reset ? aluc_c : ALU_ADD;
    assign illegal     = ill_q;
    assign busErr      = berr_q;
    assign state       = cur;

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Multi-cycle control FSM that sequences the single-register-file datapath.
- Decodes the opcode and funct fields, then drives every datapath select/enable: memToReg, pcSrc, aluSrc, regDst, writeEnable, jump, aluControl.
- Also drives PC/IR load enables and handshakes with instruction/data memory through memRead/memWrite/memReady.
- Sits between the instruction register and the datapath; one instance per core.

Parameters:
- N, 32, instruction/data width; opcode = instruction[N-1:N-6], funct = instruction[5:0].
- MEM_WAIT_MAX, 15, maximum cycles spent waiting on memReady before a bus-timeout error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  N  current instruction from the IR.
- zero  input  1  ALU zero flag.
- memReady  input  1  memory has completed the current read/write.
- memToReg  output  1  result mux select: 1 = memory data.
- pcSrc  output  1  1 = branch target.
- aluSrc  output  1  1 = sign-extended immediate.
- regDst  output  1  1 = rd field, 0 = rt field.
- writeEnable  output  1  register file write strobe.
- jump  output  1  jump select to the PC mux.
- aluControl  output  4  ALU operation code.
- pcEnable  output  1  PC register load.
- irEnable  output  1  instruction register load.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- illegal  output  1  sticky: undecodable opcode/funct seen.
- busErr  output  1  sticky: memory wait exceeded MEM_WAIT_MAX.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset (reset=0, async): state=FETCH. All outputs 0, including sticky flags and wait counter. aluControl=4'b0010.
- Release of reset is sampled on the next rising clk.
- States: FETCH(0), DECODE(1), EXECUTE(2), MEMORY(3), WRITEBACK(4).
- Outputs are Moore, from the state and the opcode/funct latched in DECODE.
- Any signal not listed for a state is 0.
- FETCH:
  - memRead=1.
  - Stay while memReady=0.
  - On memReady=1: irEnable=1 that cycle, go to DECODE.
- DECODE (1 cycle): latch opcode and funct, then branch:
  - J (6'h02): jump=1, pcEnable=1, go to FETCH.
  - Other legal opcodes: go to EXECUTE.
  - Illegal opcode: set illegal, pcEnable=1 (skip the instruction), go to FETCH.
- EXECUTE, R-type (6'h00):
  - aluControl from funct: 0x20 ADD=0010, 0x22 SUB=0110, 0x24 AND=0000, 0x25 OR=0001, 0x2A SLT=0111.
  - Go to WRITEBACK.
  - Unknown funct: set illegal, pcEnable=1, go to FETCH.
- EXECUTE, ADDI (6'h08): aluSrc=1, ADD, go to WRITEBACK.
- EXECUTE, LW (6'h23) / SW (6'h2B): aluSrc=1, ADD, go to MEMORY.
- EXECUTE, BEQ (6'h04): SUB, pcSrc=zero (combinational), pcEnable=1, go to FETCH.
- MEMORY:
  - aluSrc=1, ADD held, so the address stays stable.
  - LW: memRead=1; on memReady go to WRITEBACK.
  - SW: memWrite=1; on memReady set pcEnable=1 and go to FETCH.
- WRITEBACK (1 cycle): writeEnable=1, pcEnable=1, go to FETCH.
  - R-type: regDst=1.
  - ADDI: regDst=0.
  - LW: regDst=0, memToReg=1, with aluSrc/ADD still held.
- Wait counter:
  - Counts cycles in FETCH or MEMORY with memReady=0; clears on state change.
  - When it reaches MEM_WAIT_MAX: set busErr, drop the request, pcEnable=1 only if in MEMORY, go to FETCH.
  - In FETCH the timeout simply restarts the fetch.
- Invariants:
  - pcEnable is asserted exactly once per retired or skipped instruction.
  - writeEnable and memWrite are never both 1.
  - memRead and memWrite are never both 1.
- Latency (with memReady the same cycle as the request):
  - R/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW and BEQ: 4 and 3 cycles.
  - J: 2 cycles.
- Reset asserted mid-instruction: immediate return to FETCH. No writeEnable/memWrite pulse is produced, and the pending instruction is discarded.
- illegal and busErr clear only on reset.

Decomposition:
- Package datapath_pkg:
  - State enum.
  - Opcode constants OP_RTYPE/OP_J/OP_BEQ/OP_ADDI/OP_LW/OP_SW.
  - Funct constants.
  - ALU code constants ALU_ADD/SUB/AND/OR/SLT.
- One natural sub-module: alu_decoder (combinational: funct → aluControl plus a funct-illegal flag), reused by the future pipelined control.
- FSM and wait counter stay in datapath_controller.

Test Plan:
- Reset held low 3 cycles, then released, memReady=1 → state=0, memRead=1, all other outputs 0.
- R-type ADD (opcode 0, funct 0x20), memReady always 1 → states 0,1,2,4,0; aluControl=0010 in EXECUTE; regDst=1 and writeEnable=1 and pcEnable=1 in the WRITEBACK cycle only.
- LW, memReady held low 3 cycles in MEMORY → memRead held 3+1 cycles, then WRITEBACK with memToReg=1, writeEnable=1. SW with the same stall → memWrite 4 cycles, pcEnable on the memReady cycle, no writeEnable.
- BEQ with zero=1 → pcSrc=1 and pcEnable=1 in EXECUTE. With zero=0 → pcSrc=0, pcEnable=1. J → jump=1, pcEnable=1 in DECODE.
- Opcode 6'h3F, and R-type funct 0x3F → illegal rises and stays 1; PC advances; writeEnable never asserted.
- memReady stuck at 0 in MEMORY (SW) → after 15 cycles busErr=1, memWrite drops, return to FETCH. Async reset asserted mid-MEMORY → outputs 0 before the next clk edge.
